pipe_skid_stage: RTL

Parametrised elastic pipeline register that generalises the fixed MEM/WB latch into a reusable stage for any inter-stage boundary of the MIPS pipeline. It carries a WIDTH-bit payload under a valid/ready handshake. A two-entry skid buffer keeps full throughput while registering the backpressure path. It adds synchronous flush (bubble insertion) and halt tracking: once a halt beat is accepted, upstream is locked out, and a sticky `halted` flag is raised when that beat retires downstream.

---
 rtl/cpu_types_pkg.sv | 33 +++
 rtl/pipe_skid_if.sv | 31 +++
 rtl/pipe_skid_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: stage-buffer state, default beat layout and a helper
// that maps a buffer state to its beat count.
package cpu_types_pkg;

  // Fill level of a two-entry elastic stage.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  // Payload width of the generic beat when no other width is chosen.
  localparam int PIPE_DEFAULT_WIDTH = 32;

  // Generic beat: halt marker travelling alongside an opaque payload.
  typedef struct packed {
    logic                          halt;
    logic [PIPE_DEFAULT_WIDTH-1:0] data;
  } pipe_beat_t;

  // Number of buffered beats represented by a stage state.
  function automatic logic [1:0] pipe_occupancy(input pipe_state_t s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      PS_ONE:  n = 2'd1;
      PS_FULL: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_skid_if.sv
// Bundle of the elastic stage handshake: the stage view and its mirror.
interface pipe_skid_if #(
  parameter int WIDTH = 32
) (
  input logic CLK
);

  logic             RST;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_halt;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_halt;
  logic             halted;
  logic [1:0]       occupancy;

  modport stage (
    input  CLK, RST, in_valid, in_data, in_halt, flush, out_ready,
    output in_ready, out_valid, out_data, out_halt, halted, occupancy
  );

  modport tb (
    input  CLK, in_ready, out_valid, out_data, out_halt, halted, occupancy,
    output RST, in_valid, in_data, in_halt, flush, out_ready
  );

endinterface

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a two-entry skid buffer, synchronous flush
// and halt tracking. in_ready is driven from registered state and RST only,
// so neither the payload nor out_ready has a combinational path upstream.
module pipe_skid_stage
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_halt,
  output logic             halted,
  output logic [1:0]       occupancy
);

  typedef struct packed {
    logic             halt;
    logic [WIDTH-1:0] data;
  } beat_t;

  pipe_state_t r_state;
  beat_t       r_main;       // head beat, drives out_*
  beat_t       r_skid;       // beat displaced by backpressure
  logic        r_halt_lock;  // a halt beat has been accepted
  logic        r_halted;     // a halt beat has left the stage

  beat_t w_in_beat;
  logic  w_in_fire;
  logic  w_out_fire;
  logic  w_halt_retire;

  assign w_in_beat     = '{halt: in_halt, data: in_data};
  assign in_ready      = !RST && (r_state != PS_FULL) && !r_halt_lock;
  assign out_valid     = (r_state != PS_EMPTY);
  assign w_in_fire     = in_valid && in_ready;
  assign w_out_fire    = out_valid && out_ready;
  assign w_halt_retire = w_out_fire && r_main.halt;

  assign out_data  = r_main.data;
  assign out_halt  = r_main.halt;
  assign halted    = r_halted;
  assign occupancy = pipe_occupancy(r_state);

  // Buffer FSM: fill/drain of the main and skid entries plus halt bookkeeping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: payload registers are cleared too, because out_data must read 0
      // straight after reset and after a flush, not merely be ignored.
      r_state     <= PS_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_halt_lock <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let every branch read the pre-edge state,
      // so a later assignment to the same register simply overrides.
      if (w_halt_retire) begin
        r_halted <= 1'b1;
      end

      if (flush) begin
        // A retiring head still counts; any beat offered this cycle is dropped.
        r_state     <= PS_EMPTY;
        r_main      <= '0;
        r_skid      <= '0;
        r_halt_lock <= r_halted || w_halt_retire;
      end else begin
        if (w_in_fire && in_halt) begin
          r_halt_lock <= 1'b1;
        end

        case (r_state)
          PS_EMPTY: begin
            if (w_in_fire) begin
              r_main  <= w_in_beat;
              r_state <= PS_ONE;
            end
          end

          PS_ONE: begin
            if (w_in_fire && w_out_fire) begin
              r_main <= w_in_beat;
            end else if (w_in_fire) begin
              r_skid  <= w_in_beat;
              r_state <= PS_FULL;
            end else if (w_out_fire) begin
              r_state <= PS_EMPTY;
            end
          end

          PS_FULL: begin
            // in_ready is low here, so only the drain side can move.
            if (w_out_fire) begin
              r_main  <= r_skid;
              r_state <= PS_ONE;
            end
          end

          default: begin
            r_state <= PS_EMPTY;
          end
        endcase
      end
    end
  end

endmodule
